// File: rtl/fm_sb_playback.sv
// fm_sb_playback: replays spy-buffer words as an fm_rt data/valid stream.
// Reads 0..last_addr once or in a loop; the stored valid bit gates fm_vld so capture gaps are preserved.
module fm_sb_playback #(
  parameter int SB_DW  = 64,
  parameter int TP_DW  = 51,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pb_mode,
  input  logic              pb_start,
  input  logic              pb_stop,
  input  logic [ADDR_W-1:0] pb_last_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [SB_DW-1:0]  mem_rd_data,
  output logic [TP_DW-1:0]  fm_data,
  output logic              fm_vld,
  output logic              pb_busy,
  output logic              pb_done,
  output logic [15:0]       pb_loop_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        r_state, r_mode;
  logic [ADDR_W-1:0] r_addr, r_last;
  logic [RD_LAT-1:0] r_pipe;
  logic [TP_DW-1:0]  r_data;
  logic [15:0]       r_cnt;
  logic              r_vld, r_done;

  wire w_fetch   = r_state == FETCH;
  wire w_at_last = r_addr == r_last;
  wire w_start   = pb_start & ~pb_stop & (pb_mode == 2'd1 | pb_mode == 2'd2);
  wire w_out_vld = r_pipe[RD_LAT-1] & mem_rd_data[TP_DW];
  wire w_unused  = ^mem_rd_data[SB_DW-1:TP_DW+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= '0;
      r_addr  <= '0;
      r_last  <= '0;
      r_pipe  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_pipe <= RD_LAT'({r_pipe, w_fetch});
      r_vld  <= w_out_vld;
      r_data <= w_out_vld ? mem_rd_data[TP_DW-1:0] : '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= FETCH;
          r_mode  <= pb_mode;
          r_last  <= pb_last_addr;
          r_addr  <= '0;
          r_cnt   <= '0;
        end
        FETCH: begin
          r_addr <= w_at_last ? '0 : r_addr + 1'b1;
          // a pass whose last read is issued counts even if stop arrives with it
          if (w_at_last && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 1'b1;
          if (pb_stop || (w_at_last && r_mode == 2'd1)) r_state <= DRAIN;
        end
        default: if (r_pipe == '0) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  assign mem_rd_en   = w_fetch;
  assign mem_rd_addr = r_addr;
  assign fm_data     = r_data;
  assign fm_vld      = r_vld;
  assign pb_busy     = r_state != IDLE;
  assign pb_done     = r_done;
  assign pb_loop_cnt = r_cnt;
endmodule

// File: tb/tb_fm_sb_playback.sv
// tb_fm_sb_playback: directed checks of fm_sb_playback against a 2-cycle-latency memory model.
module tb_fm_sb_playback;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  pb_mode = '0;
  logic        pb_start = 1'b0, pb_stop = 1'b0;
  logic [9:0]  pb_last_addr = '0;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic [50:0] fm_data;
  logic        fm_vld, pb_busy, pb_done;
  logic [15:0] pb_loop_cnt;
  logic [63:0] mem [1024];
  logic [63:0] d1 = '0, d2 = '0;
  int n_vec = 0, n_err = 0;

  fm_sb_playback dut (
    .clk(clk), .rst_n(rst_n), .pb_mode(pb_mode), .pb_start(pb_start), .pb_stop(pb_stop),
    .pb_last_addr(pb_last_addr), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .fm_data(fm_data), .fm_vld(fm_vld), .pb_busy(pb_busy),
    .pb_done(pb_done), .pb_loop_cnt(pb_loop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= mem_rd_en ? mem[mem_rd_addr] : '0;
    d2 <= d1;
  end
  assign mem_rd_data = d2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 1024; i++) mem[i] = (64'd1 << 51) | 64'(32'hA0 + i);
  endtask

  task automatic start(input logic [1:0] m, input logic [9:0] la);
    pb_mode = m;
    pb_last_addr = la;
    pb_start = 1'b1;
    @(negedge clk);
    pb_start = 1'b0;
    pb_mode = 2'd0;
    pb_last_addr = '0;
  endtask

  task automatic run_single(input int last);
    logic ev;
    start(2'd1, 10'(last));
    for (int k = 1; k <= last + 5; k++) begin
      chk("rd_en", mem_rd_en, k <= last + 1);
      if (k <= last + 1) chk("rd_addr", mem_rd_addr, 64'(k - 1));
      ev = (k >= 4 && k - 4 <= last) ? mem[k - 4][51] : 1'b0;
      chk("fm_vld", fm_vld, ev);
      chk("fm_data", fm_data, ev ? 64'(mem[k - 4][50:0]) : 64'd0);
      chk("pb_done", pb_done, k == last + 5);
      @(negedge clk);
    end
    chk("loop_cnt", pb_loop_cnt, 1);
    chk("busy_end", pb_busy, 0);
  endtask

  task automatic idle_check(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk(tag, {mem_rd_en, pb_busy}, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    fill();
    @(negedge clk);
    chk("rst_outs", {mem_rd_en, fm_vld, pb_busy, pb_done}, 0);
    chk("rst_cnt", pb_loop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_single(3);
    mem[1][51] = 1'b0;
    run_single(3);
    fill();
    run_single(0);
    // loop mode: ten reads then stop
    start(2'd2, 10'd1);
    for (int k = 1; k <= 10; k++) begin
      chk("loop_en", mem_rd_en, 1);
      chk("loop_addr", mem_rd_addr, 64'((k - 1) % 2));
      if (k >= 4) chk("loop_vld", fm_vld, 1);
      if (k == 10) pb_stop = 1'b1;
      @(negedge clk);
      pb_stop = 1'b0;
    end
    for (int k = 11; k <= 14; k++) begin
      chk("loop_stop_en", mem_rd_en, 0);
      if (k == 11) chk("loop_cnt5", pb_loop_cnt, 5);
      chk("loop_drain_vld", fm_vld, k <= 13);
      chk("loop_done", pb_done, k == 14);
      @(negedge clk);
    end
    // mode and handshake corners
    pb_mode = 2'd0; pb_start = 1'b1; @(negedge clk); pb_start = 1'b0;
    idle_check("mode0_idle");
    pb_mode = 2'd3; pb_start = 1'b1; @(negedge clk); pb_start = 1'b0;
    idle_check("mode3_idle");
    pb_mode = 2'd1; pb_start = 1'b1; pb_stop = 1'b1; @(negedge clk); pb_start = 1'b0; pb_stop = 1'b0;
    idle_check("startstop_idle");
    start(2'd1, 10'd7);
    for (int k = 1; k <= 9; k++) begin
      pb_mode = 2'd1;
      pb_start = (k == 3);
      chk("restart_en", mem_rd_en, k <= 8);
      if (k <= 8) chk("restart_addr", mem_rd_addr, 64'(k - 1));
      @(negedge clk);
    end
    pb_start = 1'b0;
    for (int k = 0; k < 20 && !pb_done; k++) @(negedge clk);
    chk("restart_done", pb_done, 1);
    chk("restart_cnt", pb_loop_cnt, 1);
    @(negedge clk);
    // abort at address 2 of an 8-word pass
    start(2'd1, 10'd7);
    for (int k = 1; k <= 3; k++) begin
      chk("abort_addr", mem_rd_addr, 64'(k - 1));
      if (k == 3) pb_stop = 1'b1;
      @(negedge clk);
    end
    pb_stop = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      chk("abort_en", mem_rd_en, 0);
      if (k == 4) chk("abort_cnt", pb_loop_cnt, 0);
      chk("abort_vld", fm_vld, k <= 6);
      chk("abort_done", pb_done, k == 7);
      @(negedge clk);
    end
    // asynchronous reset mid-pass
    start(2'd1, 10'd7);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    chk("pre_rst_vld", fm_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {mem_rd_en, fm_vld, pb_busy, pb_done}, 0);
    chk("rst_mid_data", fm_data, 0);
    chk("rst_mid_addr", mem_rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("post_rst", {mem_rd_en, fm_vld, pb_busy}, 0);
      @(negedge clk);
    end
    // full-range loop wraps 1023 -> 0
    start(2'd2, 10'd1023);
    for (int k = 1; k < 1024; k++) @(negedge clk);
    chk("wrap_last", mem_rd_addr, 1023);
    chk("wrap_cnt0", pb_loop_cnt, 0);
    @(negedge clk);
    chk("wrap_zero", mem_rd_addr, 0);
    chk("wrap_en", mem_rd_en, 1);
    chk("wrap_cnt1", pb_loop_cnt, 1);
    pb_stop = 1'b1;
    @(negedge clk);
    pb_stop = 1'b0;
    for (int k = 0; k < 20 && !pb_done; k++) @(negedge clk);
    chk("wrap_done", pb_done, 1);
    chk("wrap_cnt_end", pb_loop_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fm_sb_playback.md
Name: fm_sb_playback

Overview:
Playback engine for one spy buffer. It reads stored words from the spy buffer memory port and re-injects them toward the user logic as an fm_rt-style data/valid stream. It is the inverse of spy capture: capture writes design traffic into the spy buffer, and this block reads it back out and drives the design. One instance sits beside each spy buffer that supports playback; control and status come from the FM_CTRL/FM_MON register map.

Parameters:
- SB_DW, 64: memory word width. Must be 32, 64, 128 or 256, i.e. the spy buffer width rounded up from the payload.
- TP_DW, 51: payload width. TP_DW must be less than SB_DW.
- ADDR_W, 10: memory address width.
- RD_LAT, 2: memory read latency in cycles, 1 to 4.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- pb_mode  in  2  playback mode. 0 = off, 1 = single pass, 2 = loop, 3 = reserved (treated as off).
- pb_start  in  1  start pulse.
- pb_stop  in  1  stop pulse.
- pb_last_addr  in  ADDR_W  last address of the playback window; the window is 0..pb_last_addr.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  SB_DW  memory read data, valid RD_LAT cycles after mem_rd_en.
- fm_data  out  TP_DW  playback payload.
- fm_vld  out  1  payload valid.
- pb_busy  out  1  high in any state other than IDLE.
- pb_done  out  1  one-cycle pulse when a playback completes.
- pb_loop_cnt  out  16  number of completed passes, saturating.

Behaviour:
- Reset: all outputs and state go to 0; the state machine goes to IDLE. Reset asserted mid-playback aborts at once, and in-flight reads are discarded.
- Word format: bits [TP_DW-1:0] are the payload and bit TP_DW is the stored valid flag. Bits above TP_DW are ignored.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - pb_start=1 with pb_mode of 1 or 2 and pb_stop=0 latches pb_mode and pb_last_addr, clears pb_loop_cnt, and moves to FETCH.
  - pb_start is ignored when pb_mode is 0 or 3.
  - If pb_start and pb_stop are high in the same cycle, stop wins and the block stays in IDLE.
- FETCH:
  - mem_rd_en=1 every cycle, with mem_rd_addr starting at 0 and incrementing by 1.
  - When the address equals the latched last address:
    - single mode: pb_loop_cnt increments and the block moves to DRAIN.
    - loop mode: the next address is 0 with no bubble cycle, and pb_loop_cnt increments (saturating at 0xFFFF).
  - pb_stop=1 aborts issuing: mem_rd_en drops the next cycle, the state goes to DRAIN, and pb_loop_cnt does not increment for the partial pass.
  - pb_start while busy is ignored. Input changes after start have no effect until the next start.
- DRAIN:
  - No new reads are issued.
  - The block waits until the RD_LAT-deep read-valid pipe and the output register are empty.
  - It then goes to IDLE and pulses pb_done for 1 cycle.
- Output path:
  - A read-valid shift pipe of RD_LAT stages tracks outstanding reads.
  - At the pipe end the outputs are registered: fm_vld = pipe_valid & mem_rd_data[TP_DW], and fm_data = mem_rd_data[TP_DW-1:0] when fm_vld is high, 0 otherwise.
  - Latency: a start seen in cycle T gives the first mem_rd_en at T+1 and the first output at T+2+RD_LAT.
  - Stored invalid words give fm_vld=0 cycles in place, so the original timing gaps are preserved.
- No backpressure: the output is one word per cycle while reads are in flight.
- pb_last_addr=0 is a legal one-word window. In loop mode it reads address 0 every cycle.

Test Plan:
- Single-pass timing: RD_LAT=2, last_addr=3, memory words carry payloads 0xA0..0xA3 all with the valid flag set, start at T.
  - mem_rd_en is high for T+1..T+4 with addresses 0..3.
  - fm_vld is high for T+4..T+7 with fm_data 0xA0..0xA3.
  - pb_done pulses at T+8 and pb_loop_cnt=1.
- Gap preservation: word 1 has its valid flag clear.
  - fm_vld pattern is 1,0,1,1.
  - fm_data is 0 in the gap cycle.
- Loop mode, last_addr=1, run 10 cycles then stop:
  - addresses sequence 0,1,0,1,... with no bubble.
  - pb_loop_cnt=5.
  - reads already in flight at stop are still delivered, then pb_done pulses.
- Mode and handshake corner cases:
  - start with pb_mode=0 or 3: no reads, pb_busy stays 0.
  - start and stop in the same cycle in IDLE: stays IDLE.
  - start while busy: no restart, address sequence unaffected.
- Abort and reset:
  - stop at address 2 of an 8-word single pass: no further reads, pb_loop_cnt=0, pb_done pulses after drain.
  - rst_n low mid-pass: all outputs 0 immediately and no stale fm_vld after release.
- Boundary cases:
  - last_addr=0 in single mode: exactly one read and one output word.
  - last_addr=2^ADDR_W-1 in loop mode: address wraps to 0 and the loop count increments.
